// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MIPS memory-stage load/store engine. Generates byte lanes and
//                store data, runs a req/ack handshake and extends load data.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int len_data    = 32,
    parameter int len_addr    = 11,
    parameter int len_mem_bus = 9,
    parameter int timeout     = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [len_mem_bus-1:0] i_mem_bus,
    input  logic [len_data-1:0]    i_addr,
    input  logic [len_data-1:0]    i_wdata,
    output logic                   o_stall,
    output logic [len_data-1:0]    o_rdata,
    output logic                   o_rdata_valid,
    output logic                   o_misaligned,
    output logic                   o_bus_err,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [len_addr-1:0]    o_mem_addr,
    output logic [3:0]             o_mem_be,
    output logic [len_data-1:0]    o_mem_wdata,
    input  logic                   i_mem_ack,
    input  logic [len_data-1:0]    i_mem_rdata
);

    localparam int c_SB       = 7;
    localparam int c_SH       = 6;
    localparam int c_LB       = 5;
    localparam int c_LH       = 4;
    localparam int c_UNSIGNED = 3;
    localparam int c_MEMREAD  = 1;
    localparam int c_MEMWRITE = 0;
    localparam logic [7:0] c_TMO = 8'(timeout);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q;
    logic [7:0]           cnt_q;
    logic [1:0]           lo_q;
    logic                 byte_q;
    logic                 half_q;
    logic                 uns_q;
    logic                 req_q;
    logic                 we_q;
    logic [len_addr-1:0]  addr_q;
    logic [3:0]           be_q;
    logic [len_data-1:0]  wdata_q;
    logic [len_data-1:0]  rdata_q;
    logic                 rdata_valid_q;
    logic                 misaligned_q;
    logic                 bus_err_q;

    logic                 w_byte;
    logic                 w_half;
    logic                 w_access;
    logic                 w_misal;
    logic                 w_accept;
    logic [3:0]           w_be;
    logic [len_data-1:0]  w_wdata;
    logic [7:0]           w_lane8;
    logic [15:0]          w_lane16;
    logic [len_data-1:0]  w_ext;
    logic                 w_unused_bits;

    assign w_unused_bits = ^{i_mem_bus[8], i_mem_bus[2], i_addr[len_data-1:len_addr+2]};

    assign w_byte   = i_mem_bus[c_SB] | i_mem_bus[c_LB];
    assign w_half   = ~w_byte & (i_mem_bus[c_SH] | i_mem_bus[c_LH]);
    assign w_access = i_valid & (i_mem_bus[c_MEMREAD] | i_mem_bus[c_MEMWRITE]);
    assign w_misal  = (w_half & i_addr[0]) | (~w_byte & ~w_half & (i_addr[1:0] != 2'b00));
    assign w_accept = (state_q == S_IDLE) & w_access & ~w_misal;

    // Stall is gated by reset so an abandoned access releases the pipeline at once.
    assign o_stall = ~reset & (w_accept | (state_q == S_BUSY));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (w_byte) begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
        end else if (w_half) begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wdata[15:0]}};
        end
    end

    always_comb begin
        w_lane8 = i_mem_rdata[7:0];
        case (lo_q)
            2'd1:    w_lane8 = i_mem_rdata[15:8];
            2'd2:    w_lane8 = i_mem_rdata[23:16];
            2'd3:    w_lane8 = i_mem_rdata[31:24];
            default: w_lane8 = i_mem_rdata[7:0];
        endcase
        w_lane16 = lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        w_ext    = i_mem_rdata;
        if (byte_q) begin
            w_ext = uns_q ? {24'h0, w_lane8} : {{24{w_lane8[7]}}, w_lane8};
        end else if (half_q) begin
            w_ext = uns_q ? {16'h0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            lo_q          <= 2'd0;
            byte_q        <= 1'b0;
            half_q        <= 1'b0;
            uns_q         <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= 4'd0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_access && w_misal) begin
                        misaligned_q <= 1'b1;
                    end else if (w_accept) begin
                        lo_q    <= i_addr[1:0];
                        byte_q  <= w_byte;
                        half_q  <= w_half;
                        uns_q   <= i_mem_bus[c_UNSIGNED];
                        we_q    <= i_mem_bus[c_MEMWRITE];
                        addr_q  <= i_addr[len_addr+1:2];
                        be_q    <= w_be;
                        wdata_q <= w_wdata;
                        req_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_mem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q       <= w_ext;
                            rdata_valid_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else if (cnt_q == c_TMO) begin
                        req_q     <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rdata       = rdata_q;
    assign o_rdata_valid = rdata_valid_q;
    assign o_misaligned  = misaligned_q;
    assign o_bus_err     = bus_err_q;
    assign o_mem_req     = req_q;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_be      = be_q;
    assign o_mem_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [8:0]  i_mem_bus;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [10:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .i_mem_bus     (i_mem_bus),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid),
        .o_misaligned  (o_misaligned),
        .o_bus_err     (o_bus_err),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_be      (o_mem_be),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        rvalid;
        logic        berr;
        logic [3:0]  be;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [8:0] bus, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input logic tmo);
        exp_t        e;
        logic        bt;
        logic        hw;
        logic [7:0]  b8;
        logic [15:0] h16;
        bt    = bus[7] | bus[5];
        hw    = !bt && (bus[6] | bus[4]);
        e.we   = bus[0];
        e.addr = a[12:2];
        b8  = rd[{a[1:0], 3'b000} +: 8];
        h16 = rd[{a[1], 4'b0000} +: 16];
        if (bt) begin
            e.be    = 4'b0001 << a[1:0];
            e.wdata = {4{wd[7:0]}};
            e.rdata = bus[3] ? {24'h0, b8} : {{24{b8[7]}}, b8};
        end else if (hw) begin
            e.be    = a[1] ? 4'b1100 : 4'b0011;
            e.wdata = {2{wd[15:0]}};
            e.rdata = bus[3] ? {16'h0, h16} : {{16{h16[15]}}, h16};
        end else begin
            e.be    = 4'b1111;
            e.wdata = wd;
            e.rdata = rd;
        end
        e.rvalid = !e.we && !tmo;
        e.berr   = tmo;
        if (tmo) e.rdata = 32'h0;
        return e;
    endfunction

    // k = cycle within BUSY that carries the ack; k = 0 never acks.
    task automatic run_access(input string tag, input logic [8:0] bus, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int k);
        exp_t cur;
        int   n;
        int   bad;
        int   stalls;
        bit   done;
        bit   got;
        @(posedge clk); #1;
        i_valid   = 1'b1;
        i_mem_bus = bus;
        i_addr    = a;
        i_wdata   = wd;
        i_mem_ack = 1'b0;
        sb.push_back(model(bus, a, wd, rd, k == 0));
        @(negedge clk);
        chk({tag, "_accept_stall"}, 32'(o_stall), 32'd1);
        chk({tag, "_accept_noreq"}, 32'(o_mem_req), 32'd0);
        n = 0; bad = 0; stalls = 1; done = 0; got = 0;
        while (!done) begin
            @(posedge clk); #1;
            n++;
            i_mem_ack   = (k != 0) && (n == k);
            i_mem_rdata = (n == k) ? rd : ~rd;
            @(negedge clk);
            if (o_mem_req) begin
                if (!got) begin
                    cur = sb.pop_front();
                    got = 1;
                end
                if (o_stall) stalls++;
                if (o_mem_addr !== cur.addr || o_mem_be !== cur.be ||
                    o_mem_we !== cur.we || o_mem_wdata !== cur.wdata) bad++;
                if (n > 300) begin
                    chk({tag, "_busy_bound"}, 32'(n), 32'd300);
                    done = 1;
                end
            end else begin
                done = 1;
            end
        end
        if (!got) begin
            chk({tag, "_req_seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            chk({tag, "_req_stable"}, 32'(bad), 32'd0);
            chk({tag, "_resp_stall"}, 32'(o_stall), 32'd0);
            chk({tag, "_resp_rvalid"}, 32'(o_rdata_valid), 32'(cur.rvalid));
            chk({tag, "_resp_berr"}, 32'(o_bus_err), 32'(cur.berr));
            if (!cur.we || cur.berr) chk({tag, "_rdata"}, o_rdata, cur.rdata);
            if (k != 0) begin
                chk({tag, "_busy_len"}, 32'(n - 1), 32'(k));
                chk({tag, "_stall_cycles"}, 32'(stalls), 32'(k + 1));
            end else begin
                chk({tag, "_tmo_len"}, 32'((n - 1 == 255) || (n - 1 == 256)), 32'd1);
            end
        end
        @(posedge clk); #1;
        i_valid   = 1'b0;
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_post_rvalid"}, 32'(o_rdata_valid), 32'd0);
        chk({tag, "_post_berr"}, 32'(o_bus_err), 32'd0);
        chk({tag, "_post_stall"}, 32'(o_stall), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        i_valid     = 1'b0;
        i_mem_bus   = 9'h0;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",  32'(o_stall), 32'd0);
        chk("rst_req",    32'(o_mem_req), 32'd0);
        chk("rst_we",     32'(o_mem_we), 32'd0);
        chk("rst_rvalid", 32'(o_rdata_valid), 32'd0);
        chk("rst_mis",    32'(o_misaligned), 32'd0);
        chk("rst_berr",   32'(o_bus_err), 32'd0);
        chk("rst_rdata",  o_rdata, 32'd0);
        chk("rst_wdata",  o_mem_wdata, 32'd0);
        chk("rst_be",     32'(o_mem_be), 32'd0);
        chk("rst_addr",   32'(o_mem_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_access("lb",   9'h022, 32'h0000_0013, 32'h0,         32'h80FF_1234, 1);
        run_access("lbu",  9'h02A, 32'h0000_0013, 32'h0,         32'h80FF_1234, 1);
        run_access("sh",   9'h041, 32'h0000_0006, 32'h0000_BEEF, 32'h0,         2);
        run_access("lw5",  9'h002, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 5);
        run_access("sb",   9'h081, 32'h0000_0005, 32'h1234_5678, 32'h0,         1);
        run_access("lh",   9'h012, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 3);
        run_access("lhu",  9'h01A, 32'h0000_0100, 32'h0,         32'h1234_8001, 1);
        run_access("sw",   9'h003, 32'h0000_1FFC, 32'hCAFE_F00D, 32'h0,         2);

        // Misaligned word load: no request, one-cycle fault pulse.
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_bus = 9'h002; i_addr = 32'h2;
        @(negedge clk);
        chk("mis_stall0", 32'(o_stall), 32'd0);
        chk("mis_req0",   32'(o_mem_req), 32'd0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("mis_pulse",  32'(o_misaligned), 32'd1);
        chk("mis_req1",   32'(o_mem_req), 32'd0);
        chk("mis_stall1", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_pulse_end", 32'(o_misaligned), 32'd0);

        run_access("tmo", 9'h002, 32'h0000_0080, 32'h0, 32'h1234_5678, 0);

        // Reset mid-BUSY, then a late ack.
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_bus = 9'h002; i_addr = 32'h20; i_mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_req_busy", 32'(o_mem_req), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rb_req",   32'(o_mem_req), 32'd0);
        chk("rb_stall", 32'(o_stall), 32'd0);
        chk("rb_be",    32'(o_mem_be), 32'd0);
        chk("rb_addr",  32'(o_mem_addr), 32'd0);
        chk("rb_we",    32'(o_mem_we), 32'd0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        reset   = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("rb_late_req",   32'(o_mem_req), 32'd0);
        chk("rb_late_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("rb_late_rvalid", 32'(o_rdata_valid), 32'd0);
        chk("rb_late_rdata",  o_rdata, 32'd0);

        run_access("lw_after_rst", 9'h002, 32'h0000_0020, 32'h0, 32'h0BAD_CAFE, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
